// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master: FSM encoding and defaults.
package apb_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic last;

  // A lone eligible requester wins; on contention the one not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Record the winner so the other requester has priority at the next contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant_en && (grant != 2'b00)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by two requesters, with round-robin grant and ACCESS timeout.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                RESET,
  input  logic [1:0]          REQ,
  input  logic [1:0]          REQ_WRITE,
  input  logic [2*ADDR_W-1:0] REQ_ADDR,
  input  logic [2*DATA_W-1:0] REQ_WDATA,
  output logic [1:0]          DONE,
  output logic                ERR,
  output logic [DATA_W-1:0]   RDATA,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_t       state;
  apb_state_t       state_next;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic [1:0]       owner;
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_en;
  logic             complete;
  logic             abort;

  // A requester still high during its own DONE cycle must not be re-granted.
  assign elig = REQ & ~DONE;

  apb_rr_arbiter u_arb (
    .clk      (PCLK),
    .rst      (RESET),
    .elig     (elig),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // State register.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and APB control decode; PREADY wins over the timeout.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig != 2'b00) begin
          grant_en   = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL       = 1'b1;
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Wait counter: cleared on the way into ACCESS, counts ACCESS cycles without PREADY.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ST_ACCESS) && !PREADY) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Latch the winner's request on grant, and report completion or timeout one cycle later.
  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      owner  <= 2'b00;
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      DONE   <= 2'b00;
      ERR    <= 1'b0;
      RDATA  <= '0;
    end else begin
      DONE <= 2'b00;
      ERR  <= 1'b0;
      if (grant_en) begin
        owner  <= grant;
        PWRITE <= grant[1] ? REQ_WRITE[1] : REQ_WRITE[0];
        PADDR  <= grant[1] ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
        PWDATA <= grant[1] ? REQ_WDATA[2*DATA_W-1:DATA_W] : REQ_WDATA[DATA_W-1:0];
      end
      if (complete) begin
        DONE <= owner;
        if (!PWRITE) RDATA <= PRDATA;
      end else if (abort) begin
        DONE <= owner;
        ERR  <= 1'b1;
      end
    end
  end

endmodule
